// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store requests onto the 8-bit RAM/IO bus and serialises
// each 1/2/4-byte access into byte cycles, returning little-endian assembled data.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy_i,
    input  logic        flush_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_data_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [1:0]  ls_size_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_done_o,
    output logic [31:0] ls_rdata_o,
    input  logic [7:0]  mem_din_i,
    input  logic        io_buffer_full_i,
    output logic [31:0] mem_a_o,
    output logic [7:0]  mem_dout_o,
    output logic        mem_wr_o
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;
    localparam logic OwnIf = 1'b0;
    localparam logic OwnLs = 1'b1;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d, len_q, len_d;
    logic        owner_q, owner_d, last_grant_q, last_grant_d;
    logic        skip_q, skip_d, frozen_q;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d, ls_done_q, ls_done_d;
    logic [31:0] if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;

    logic        io_hold, if_ok, ls_ok, grant_ls, grant_if;
    logic [2:0]  ls_len, target;
    logic [1:0]  cap_lane, wr_lane;
    logic [31:0] cap_word;

    // Arbitration, length decode and byte-lane helpers.
    always_comb begin
        io_hold  = ls_we_i && (ls_addr_i[17:16] == 2'b11) && io_buffer_full_i;
        if_ok    = if_req_i && !flush_i;
        ls_ok    = ls_req_i && !io_hold;
        grant_ls = ls_ok && (!if_ok || (last_grant_q == OwnIf));
        grant_if = if_ok && !grant_ls;
        unique case (ls_size_i)
            2'd0:    ls_len = 3'd1;
            2'd1:    ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
        // skip_q set: lanes 0..cnt-1 captured; clear: lane cnt-1 is still in the RAM pipeline.
        target   = skip_q ? cnt_q : cnt_q - 3'd1;
        cap_lane = cnt_q[1:0] - 2'd1;
        wr_lane  = cnt_q[1:0] + 2'd1;
        cap_word = buf_q;
        cap_word[{cap_lane, 3'b000} +: 8] = mem_din_i;
    end

    // Next-state logic: flush abort, grant, byte sequencing, freeze recovery.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        skip_d       = skip_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        mem_wr_d     = mem_wr_q;
        if_done_d    = 1'b0;
        ls_done_d    = 1'b0;
        if_data_d    = if_data_q;
        ls_rdata_d   = ls_rdata_q;
        if (flush_i && (state_q == StRead) && (owner_q == OwnIf)) begin
            state_d = StIdle;
            mem_a_d = '0;
            skip_d  = 1'b0;
            cnt_d   = '0;
            buf_d   = '0;
        end else if (rdy_i) begin
            unique case (state_q)
                StIdle: begin
                    if (grant_ls) begin
                        owner_d      = OwnLs;
                        last_grant_d = OwnLs;
                        addr_d       = ls_addr_i;
                        len_d        = ls_len;
                        cnt_d        = '0;
                        mem_a_d      = ls_addr_i;
                        buf_d        = '0;
                        if (ls_we_i) begin
                            wdata_d    = ls_wdata_i;
                            mem_dout_d = ls_wdata_i[7:0];
                            mem_wr_d   = 1'b1;
                            state_d    = StWrite;
                        end else begin
                            mem_wr_d = 1'b0;
                            skip_d   = 1'b1;
                            state_d  = StRead;
                        end
                    end else if (grant_if) begin
                        owner_d      = OwnIf;
                        last_grant_d = OwnIf;
                        addr_d       = if_addr_i;
                        len_d        = 3'd4;
                        cnt_d        = '0;
                        mem_a_d      = if_addr_i;
                        buf_d        = '0;
                        mem_wr_d     = 1'b0;
                        skip_d       = 1'b1;
                        state_d      = StRead;
                    end
                end
                StRead: begin
                    if (frozen_q) begin
                        // RAM kept running while frozen: refetch the oldest missing byte.
                        mem_a_d = addr_q + 32'(target);
                        cnt_d   = target;
                        skip_d  = 1'b1;
                    end else if (!skip_q && (cnt_q == len_q)) begin
                        mem_a_d = '0;
                        state_d = StIdle;
                        if (owner_q == OwnLs) begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = cap_word;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = cap_word;
                        end
                    end else begin
                        if (!skip_q) buf_d = cap_word;
                        if ((cnt_q + 3'd1) < len_q) mem_a_d = addr_q + 32'(cnt_q) + 32'd1;
                        cnt_d  = cnt_q + 3'd1;
                        skip_d = 1'b0;
                    end
                end
                StWrite: begin
                    if ((cnt_q + 3'd1) < len_q) begin
                        cnt_d      = cnt_q + 3'd1;
                        mem_a_d    = addr_q + 32'(cnt_q) + 32'd1;
                        mem_dout_d = wdata_q[{wr_lane, 3'b000} +: 8];
                    end else begin
                        mem_wr_d  = 1'b0;
                        mem_a_d   = '0;
                        ls_done_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State register with synchronous reset; frozen_q tracks rdy even while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            len_q        <= '0;
            owner_q      <= OwnIf;
            last_grant_q <= OwnIf;
            skip_q       <= 1'b0;
            frozen_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= 1'b0;
            if_done_q    <= 1'b0;
            ls_done_q    <= 1'b0;
            if_data_q    <= '0;
            ls_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            skip_q       <= skip_d;
            frozen_q     <= !rdy_i;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            mem_wr_q     <= mem_wr_d;
            if_done_q    <= if_done_d;
            ls_done_q    <= ls_done_d;
            if_data_q    <= if_data_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    assign mem_a_o    = mem_a_q;
    assign mem_dout_o = mem_dout_q;
    assign mem_wr_o   = mem_wr_q & rdy_i;
    assign if_done_o  = if_done_q;
    assign if_data_o  = if_data_q;
    assign ls_done_o  = ls_done_q;
    assign ls_rdata_o = ls_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed checks of mem_ctrl against a byte-array memory model.
module tb_mem_ctrl;
    logic        clk, rst, rdy, flush;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_we, ls_done;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic        io_full, mem_wr;
    logic [31:0] mem_a;

    logic [7:0]  ram     [0:262143];
    logic [7:0]  ref_mem [0:262143];
    logic        bd_we;
    logic [17:0] bd_a;
    logic [7:0]  bd_d;
    logic [39:0] wr_log[$];
    int          n_cmp, n_bad;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy_i(rdy), .flush_i(flush),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done), .if_data_o(if_data),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_size_i(ls_size), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_done_o(ls_done), .ls_rdata_o(ls_rdata),
        .mem_din_i(mem_din), .io_buffer_full_i(io_full), .mem_a_o(mem_a),
        .mem_dout_o(mem_dout), .mem_wr_o(mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM with a bench backdoor write port.
    always @(posedge clk) begin
        if (bd_we) ram[bd_a] <= bd_d;
        else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        mem_din <= ram[mem_a[17:0]];
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input int n);
        logic [31:0] r, p;
        r = '0;
        for (int b = 0; b < n; b++) begin
            p = a + 32'(b);
            r[8*b +: 8] = ref_mem[p[17:0]];
        end
        return r;
    endfunction

    task automatic model_wr(input logic [31:0] a, input int n, input logic [31:0] wd);
        logic [31:0] p;
        for (int b = 0; b < n; b++) begin
            p = a + 32'(b);
            ref_mem[p[17:0]] = wd[8*b +: 8];
        end
    endtask

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_a = a; bd_d = d;
        ref_mem[a] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction; lat counts edges from the request edge to the done edge.
    task automatic xact(input bit is_if, input logic we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit rr,
                        output logic [31:0] rdata, output int lat, output bit ok);
        wr_log.delete();
        ok = 1'b0; lat = -1; rdata = '0;
        @(negedge clk);
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            ls_req = 1'b1; ls_we = we; ls_size = size; ls_addr = addr; ls_wdata = wdata;
        end
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (is_if ? if_done : ls_done) begin
                rdata = is_if ? if_data : ls_rdata;
                lat = k - 1; ok = 1'b1;
                break;
            end
            if (rr) rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (mem_wr) wr_log.push_back({mem_a, mem_dout});
        end
        if_req = 1'b0; ls_req = 1'b0; rdy = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (mem_a !== 32'd0) begin n_bad++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        n_cmp++; if (mem_wr !== 1'b0 || mem_dout !== 8'd0) begin
            n_bad++; $display("FAIL reset_wr got wr=%b dout=%h exp 0/00", mem_wr, mem_dout); end
        n_cmp++; if (if_done !== 1'b0 || ls_done !== 1'b0) begin
            n_bad++; $display("FAIL reset_done got if=%b ls=%b exp 0/0", if_done, ls_done); end
        n_cmp++; if (if_data !== 32'd0 || ls_rdata !== 32'd0) begin
            n_bad++; $display("FAIL reset_data got if=%h ls=%h exp 0/0", if_data, ls_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        logic [31:0] d; int lat; bit ok;
        xact(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, d, lat, ok);
        n_cmp++; if (d !== 32'h00000513) begin n_bad++; $display("FAIL fetch_data got=%h exp=00000513", d); end
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL fetch_lat got=%0d exp=5", lat); end
        @(negedge clk);
        n_cmp++; if (if_done !== 1'b0) begin n_bad++; $display("FAIL fetch_pulse got=%b exp=0", if_done); end
    endtask

    task automatic test_load();
        logic [31:0] d; int lat; bit ok;
        xact(1'b0, 1'b0, 2'd0, 32'h101, 32'h0, 1'b0, d, lat, ok);
        n_cmp++; if (d !== 32'h000000FF) begin n_bad++; $display("FAIL lb_data got=%h exp=000000ff", d); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lb_lat got=%0d exp=2", lat); end
        xact(1'b0, 1'b0, 2'd1, 32'h100, 32'h0, 1'b0, d, lat, ok);
        n_cmp++; if (d !== 32'h0000FF34) begin n_bad++; $display("FAIL lh_data got=%h exp=0000ff34", d); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL lh_lat got=%0d exp=3", lat); end
    endtask

    task automatic test_store();
        logic [31:0] d, w; int lat; bit ok;
        w = 32'hDEADBEEF;
        xact(1'b0, 1'b1, 2'd2, 32'h200, w, 1'b0, d, lat, ok);
        model_wr(32'h200, 4, w);
        n_cmp++; if (wr_log.size() !== 4) begin
            n_bad++; $display("FAIL sw_wr_cycles got=%0d exp=4", wr_log.size()); end
        for (int i = 0; i < wr_log.size() && i < 4; i++) begin
            n_cmp++;
            if (wr_log[i] !== {32'h200 + 32'(i), w[8*i +: 8]}) begin
                n_bad++; $display("FAIL sw_byte%0d got=%h exp=%h", i, wr_log[i],
                                  {32'h200 + 32'(i), w[8*i +: 8]});
            end
        end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL sw_lat got=%0d exp=4", lat); end
        xact(1'b0, 1'b0, 2'd2, 32'h200, 32'h0, 1'b0, d, lat, ok);
        n_cmp++; if (d !== w) begin n_bad++; $display("FAIL sw_readback got=%h exp=%h", d, w); end
    endtask

    task automatic test_contention();
        int order[$];
        do_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h1000;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h1020;
        for (int k = 0; k < 400 && order.size() < 6; k++) begin
            @(negedge clk);
            if (if_done) begin
                n_cmp++; if (if_data !== exp_rd(if_addr, 4)) begin
                    n_bad++; $display("FAIL rr_if_data got=%h exp=%h", if_data, exp_rd(if_addr, 4)); end
                order.push_back(0);
                if_addr = if_addr + 32'd4;
            end
            if (ls_done) begin
                n_cmp++; if (ls_rdata !== exp_rd(ls_addr, 1)) begin
                    n_bad++; $display("FAIL rr_ls_data got=%h exp=%h", ls_rdata, exp_rd(ls_addr, 1)); end
                order.push_back(1);
                ls_addr = ls_addr + 32'd1;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        n_cmp++; if (order.size() !== 6) begin n_bad++; $display("FAIL rr_count got=%0d exp=6", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            n_cmp++; if (order[i] !== ((i % 2 == 0) ? 1 : 0)) begin
                n_bad++; $display("FAIL rr_order%0d got=%0d exp=%0d", i, order[i], (i % 2 == 0) ? 1 : 0); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] d; int lat; bit ok, seen;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h1000;
        repeat (3) @(negedge clk);
        flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (if_done !== 1'b0 || mem_a !== 32'd0) begin
            n_bad++; $display("FAIL flush_abort got done=%b a=%h exp 0/0", if_done, mem_a); end
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (if_done) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_no_done got=%b exp=0", seen); end
        xact(1'b1, 1'b0, 2'd0, 32'h40, 32'h0, 1'b0, d, lat, ok);
        n_cmp++; if (d !== exp_rd(32'h40, 4) || lat !== 5) begin
            n_bad++; $display("FAIL flush_refetch got=%h/%0d exp=%h/5", d, lat, exp_rd(32'h40, 4)); end
        // Flush during a store must not stop it.
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h1080; ls_wdata = 32'h11223344;
        model_wr(32'h1080, 4, 32'h11223344);
        seen = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            flush = (k == 2);
            if (ls_done) begin seen = 1'b1; break; end
        end
        flush = 1'b0; ls_req = 1'b0;
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL flush_store_done got=%b exp=1", seen); end
        xact(1'b0, 1'b0, 2'd2, 32'h1080, 32'h0, 1'b0, d, lat, ok);
        n_cmp++; if (d !== 32'h11223344) begin n_bad++; $display("FAIL flush_store_data got=%h exp=11223344", d); end
    endtask

    task automatic test_io_rdy();
        logic [31:0] d; int lat, nwr; bit ok, bad, seen, fseen;
        io_full = 1'b1;
        model_wr(32'h30000, 1, 32'h5A);
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h5A;
        if_req = 1'b1; if_addr = 32'h1010;
        bad = 1'b0; fseen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_wr || ls_done) bad = 1'b1;
            if (if_done) begin
                fseen = 1'b1; if_req = 1'b0;
                n_cmp++; if (if_data !== exp_rd(32'h1010, 4)) begin
                    n_bad++; $display("FAIL io_if_data got=%h exp=%h", if_data, exp_rd(32'h1010, 4)); end
            end
        end
        if_req = 1'b0;
        n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL io_hold got=%b exp=0", bad); end
        n_cmp++; if (fseen !== 1'b1) begin n_bad++; $display("FAIL io_if_grant got=%b exp=1", fseen); end
        io_full = 1'b0;
        seen = 1'b0; nwr = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ls_done) begin seen = 1'b1; break; end
            if (mem_wr) nwr++;
        end
        ls_req = 1'b0;
        n_cmp++; if (seen !== 1'b1 || nwr !== 1) begin
            n_bad++; $display("FAIL io_release got done=%b wr=%0d exp 1/1", seen, nwr); end
        xact(1'b0, 1'b0, 2'd0, 32'h30000, 32'h0, 1'b0, d, lat, ok);
        n_cmp++; if (d !== 32'h5A) begin n_bad++; $display("FAIL io_readback got=%h exp=5a", d); end
        // rdy low for 3 cycles at each point of a word fetch.
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h1000 + 32'(4 * s);
            seen = 1'b0; d = '0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (if_done) begin seen = 1'b1; d = if_data; break; end
                if (k == s) rdy = 1'b0;
                if (k == s + 3) rdy = 1'b1;
            end
            if_req = 1'b0; rdy = 1'b1;
            n_cmp++; if (seen !== 1'b1 || d !== exp_rd(32'h1000 + 32'(4 * s), 4)) begin
                n_bad++; $display("FAIL rdy_stall%0d got done=%b d=%h exp=%h", s, seen, d,
                                  exp_rd(32'h1000 + 32'(4 * s), 4)); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, d, e; logic [1:0] sz; int kind, n, lat; bit rr, ok;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            sz   = 2'($urandom_range(0, 2));
            a    = 32'h1000 + 32'($urandom_range(0, 252));
            wd   = $urandom;
            rr   = 1'($urandom_range(0, 1));
            if (kind == 0) a = a & ~32'h3;
            n = (kind == 0) ? 4 : nbytes(sz);
            e = exp_rd(a, n);
            xact(kind == 0, kind == 2, sz, a, wd, rr, d, lat, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rand%0d_timeout got=%b exp=1", i, ok); end
            if (kind != 2) begin
                n_cmp++; if (d !== e) begin n_bad++; $display("FAIL rand%0d_data got=%h exp=%h", i, d, e); end
            end else begin
                model_wr(a, n, wd);
                n_cmp++; if (wr_log.size() !== n) begin
                    n_bad++; $display("FAIL rand%0d_nwr got=%0d exp=%0d", i, wr_log.size(), n); end
                for (int b = 0; b < wr_log.size() && b < n; b++) begin
                    n_cmp++; if (wr_log[b] !== {a + 32'(b), wd[8*b +: 8]}) begin
                        n_bad++; $display("FAIL rand%0d_wr%0d got=%h exp=%h", i, b, wr_log[b],
                                          {a + 32'(b), wd[8*b +: 8]}); end
                end
            end
            if (!rr) begin
                n_cmp++; if (lat !== ((kind == 2) ? n : n + 1)) begin
                    n_bad++; $display("FAIL rand%0d_lat got=%0d exp=%0d", i, lat, (kind == 2) ? n : n + 1); end
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
        bd_we = 1'b0; bd_a = '0; bd_d = '0;
        repeat (2) @(posedge clk);
        test_reset();
        poke(18'h0, 8'h13); poke(18'h1, 8'h05); poke(18'h2, 8'h00); poke(18'h3, 8'h00);
        poke(18'h100, 8'h34); poke(18'h101, 8'hFF);
        for (int i = 0; i < 4; i++) poke(18'h40 + 18'(i), 8'($urandom));
        for (int i = 0; i < 256; i++) poke(18'h1000 + 18'(i), 8'($urandom));
        test_fetch();
        test_load();
        test_store();
        test_contention();
        test_flush();
        test_io_rdy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller and arbiter between the instruction fetch stage and the load/store buffer. It owns the 8-bit RAM/IO bus, grants one requester at a time, serialises each 1/2/4-byte access into byte cycles, and returns a one-cycle completion pulse with the assembled little-endian data. Fetches in flight are abandoned on a pipeline flush; load/store operations always run to completion.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes the block
- flush  in  1  pipeline redirect (jump/mispredict); kills any fetch in flight
- if_req  in  1  fetch request, held until if_done or flush
- if_addr  in  32  fetch address, word aligned
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched instruction
- ls_req  in  1  load/store request, held until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  0 = byte, 1 = half, 2 = word
- ls_addr  in  32  access address
- ls_wdata  in  32  store data (low bytes used)
- ls_done  out  1  one-cycle pulse: completion; ls_rdata valid for loads
- ls_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read byte (registered in RAM, one cycle after mem_a)
- io_buffer_full  in  1  UART buffer full
- mem_a  out  32  RAM byte address
- mem_dout  out  8  RAM write byte
- mem_wr  out  1  1 = write

## Operation
- States: IDLE, READ, WRITE. Byte counter `cnt` (3 bits), length `n` (1/2/4), owner bit (IF/LS), `last_grant` bit.
- Reset: state IDLE; mem_a=0, mem_dout=0, mem_wr=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0, last_grant=IF.
- Arbitration in IDLE: only one request -> grant it. Both -> grant the one not equal to last_grant (round-robin). On the flush edge no IF grant is made.
- IO store hold: a store with ls_addr[17:16]==2'b11 is not granted while io_buffer_full=1; IF may be granted instead.
- Grant load/fetch: mem_a<=addr, mem_wr<=0, cnt<=0, state READ. n=4 for fetch.
- READ: at each edge, capture mem_din into byte lane cnt-1 (skipped while cnt=0), advance mem_a to addr+cnt+1 while bytes remain, increment cnt. When lane n-1 is captured: pulse the owner's done, drive the assembled data (upper lanes zero), mem_a<=0, state IDLE.
- Grant store: mem_a<=addr, mem_dout<=wdata[7:0], mem_wr<=1, state WRITE. Each edge: present the next byte at addr+k. After byte n-1 has been presented for one cycle: mem_wr<=0, mem_a<=0, ls_done pulse, state IDLE.
- flush during an IF READ: state IDLE, mem_a<=0, no if_done, and the captured bytes are discarded. flush during an LS operation: ignored.
- done pulses are exactly one cycle wide. Requesters must drop or change req on the cycle after done.
- rdy=0: all registers hold. mem_wr is gated low combinationally. If the freeze occurred in READ, the first rdy=1 edge re-presents the address of the oldest uncaptured byte and suppresses capture. Normal sequencing resumes the next edge.
- Misaligned half/word accesses are legal; bytes are addressed sequentially.

## Timing
- Request sampled at edge T with the block in IDLE: mem_a=addr from T.
- Read of n bytes: done visible in the cycle after edge T+n+1 (word: T+5; byte: T+2).
- Write of n bytes: mem_wr high for cycles T..T+n-1. ls_done visible after edge T+n.
- Back-to-back: the next grant can occur on the edge after done, because the done edge returns to IDLE and the following edge grants.
- Reset has priority over flush, which has priority over rdy-gated sequencing.

## Test plan
- Word fetch: RAM[0..3]=13,05,00,00 (LE), if_req with addr 0 -> if_data=0x00000513, if_done 5 cycles after the request edge, single pulse.
- Byte/half load: RAM[0x101]=0xFF; lb at 0x101 -> ls_rdata=0x000000FF. lh at 0x100 with RAM[0x100]=0x34 -> ls_rdata=0x0000FF34.
- Word store 0xDEADBEEF at 0x200 -> mem_wr high 4 cycles with mem_a 0x200..0x203 and mem_dout EF,BE,AD,DE. Readback gives the same word.
- Contention: if_req and ls_req asserted together and held -> grants alternate (LS, IF, LS, ...), and no requester is served twice in a row while the other is waiting.
- Flush mid-fetch at cnt=2 -> no if_done, mem_a=0 next cycle. A new if_req at 0x40 completes correctly. Flush during a store -> the store still finishes with ls_done.
- IO and rdy: store to 0x30000 with io_buffer_full=1 for 10 cycles -> mem_wr stays 0, then the write completes after release. rdy=0 for 3 cycles during a word fetch -> the correct word is still returned.
